// File: rtl/interrupt_controller.sv
// -----------------------------------------------------------------------------
// interrupt_controller
//
// Purpose:
//   Five-source interrupt controller with memory-mapped flag (IF, 0xFF0F) and
//   enable (IE, 0xFFFF) registers. Rising edges on the peripheral request lines
//   latch pending flags. A small IDLE/GRANT/HOLD dispatch FSM hands the
//   highest-priority pending, enabled source to the CPU. Priority is fixed,
//   with bit0 highest.
//
// Configuration:
//   INTC_JOYPAD_EN - when defined, source 4 (joypad) is fully functional.
//                    When undefined, IF[4] is never set, reads 0, and never
//                    acknowledges. IE[4] is still stored and readable.
//
// Ports:
//   clk          in   1  system clock, rising edge
//   rst          in   1  asynchronous reset, active-low
//   a            in  16  bus address
//   din          in   8  bus write data
//   dout         out  8  bus read data (combinational from a)
//   rd           in   1  bus read strobe (reads are side-effect free)
//   wr           in   1  bus write strobe
//   int_req      in   5  request levels: vblank, lcd stat, timer, serial, joypad
//   int_ack      out  5  one-cycle acknowledge pulse, one-hot, during GRANT
//   cpu_int      out  1  any enabled flag pending
//   cpu_int_ack  in   1  CPU dispatch request, held until dispatch completes
//   int_vector   out  8  dispatch vector, valid in GRANT/HOLD, 0 otherwise
// -----------------------------------------------------------------------------
module interrupt_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] a,
    input  logic [7:0]  din,
    output logic [7:0]  dout,
    input  logic        rd,
    input  logic        wr,
    input  logic [4:0]  int_req,
    output logic [4:0]  int_ack,
    output logic        cpu_int,
    input  logic        cpu_int_ack,
    output logic [7:0]  int_vector
);

    localparam logic [15:0] ADDR_IF = 16'hFF0F;
    localparam logic [15:0] ADDR_IE = 16'hFFFF;

`ifdef INTC_JOYPAD_EN
    localparam logic [4:0] SRC_MASK = 5'b11111;
`else
    localparam logic [4:0] SRC_MASK = 5'b01111;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      state;
    logic [4:0]  if_q;
    logic [7:0]  ie_q;
    logic [4:0]  req_prev;
    logic        armed;
    logic [2:0]  sel_n;

    logic        if_wr;
    logic        ie_wr;
    logic [4:0]  edges;
    logic [4:0]  dispatch_clr;
    logic [4:0]  if_next;
    logic [4:0]  pending;
    logic [2:0]  pick;

    // Reads have no side effects, so the read strobe carries no information.
    logic        unused_rd;
    assign unused_rd = rd;

    // Lowest-numbered set bit wins; the result is ignored when nothing is set.
    function automatic logic [2:0] lowest_set(input logic [4:0] v);
        logic [2:0] n;
        casez (v)
            5'b????1: n = 3'd0;
            5'b???10: n = 3'd1;
            5'b??100: n = 3'd2;
            5'b?1000: n = 3'd3;
            5'b10000: n = 3'd4;
            default:  n = 3'd0;
        endcase
        return n;
    endfunction

    function automatic logic [4:0] onehot5(input logic [2:0] n);
        return 5'b00001 << n;
    endfunction

    // Vector table starts at 0x40 with an 8-byte stride per source.
    function automatic logic [7:0] vector_of(input logic [2:0] n);
        return {2'b01, n, 3'b000};
    endfunction

    // ---------------------------------------------------------------------
    // Bus decode, edge detection and next-flag computation
    // ---------------------------------------------------------------------
    assign if_wr = wr && (a == ADDR_IF);
    assign ie_wr = wr && (a == ADDR_IE);

    // The first cycle after reset only loads req_prev. A line already high
    // at release is therefore not mistaken for a fresh edge.
    assign edges = armed ? (int_req & ~req_prev & SRC_MASK) : 5'b00000;

    assign dispatch_clr = (state == GRANT) ? onehot5(sel_n) : 5'b00000;

    // Ordering gives edges priority over both bus writes and dispatch clears.
    assign if_next = (((if_wr ? din[4:0] : if_q) & ~dispatch_clr) | edges) & SRC_MASK;

    assign pending = ie_q[4:0] & if_q;
    assign cpu_int = |pending;
    assign pick    = lowest_set(pending);

    always_comb begin
        dout = 8'hFF;
        if (a == ADDR_IF) begin
            dout = {3'b111, if_q};
        end else if (a == ADDR_IE) begin
            dout = ie_q;
        end
    end

    // ---------------------------------------------------------------------
    // Flag / enable / request-history registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_q     <= 5'b00000;
            ie_q     <= 8'h00;
            req_prev <= 5'b00000;
            armed    <= 1'b0;
        end else begin
            if_q     <= if_next;
            req_prev <= int_req;
            armed    <= 1'b1;
            if (ie_wr) begin
                ie_q <= din;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Dispatch FSM
    // ---------------------------------------------------------------------
    // Source and vector are captured on entry to GRANT and stay frozen until
    // IDLE. Later IE/IF writes or new requests therefore cannot redirect a
    // dispatch that is already in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            sel_n      <= 3'd0;
            int_ack    <= 5'b00000;
            int_vector <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    int_ack <= 5'b00000;
                    if (cpu_int_ack && cpu_int) begin
                        state      <= GRANT;
                        sel_n      <= pick;
                        int_vector <= vector_of(pick);
                        int_ack    <= onehot5(pick) & SRC_MASK;
                    end else begin
                        int_vector <= 8'h00;
                    end
                end
                GRANT: begin
                    int_ack <= 5'b00000;
                    state   <= HOLD;
                end
                HOLD: begin
                    int_ack <= 5'b00000;
                    if (!cpu_int_ack) begin
                        state      <= IDLE;
                        int_vector <= 8'h00;
                    end
                end
                default: begin
                    state      <= IDLE;
                    int_ack    <= 5'b00000;
                    int_vector <= 8'h00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// -----------------------------------------------------------------------------
// tb_interrupt_controller
//
// Purpose:
//   Directed, self-checking bench for interrupt_controller. Inputs change on
//   the falling clock edge and outputs are sampled on the next falling edge.
//   Each scenario lives in its own task.
//   Joypad expectations follow INTC_JOYPAD_EN.
// -----------------------------------------------------------------------------
module tb_interrupt_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] a;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic        rd;
    logic        wr;
    logic [4:0]  int_req;
    logic [4:0]  int_ack;
    logic        cpu_int;
    logic        cpu_int_ack;
    logic [7:0]  int_vector;

    int pass_cnt = 0;
    int total_cnt = 0;

    interrupt_controller dut (
        .clk         (clk),
        .rst         (rst),
        .a           (a),
        .din         (din),
        .dout        (dout),
        .rd          (rd),
        .wr          (wr),
        .int_req     (int_req),
        .int_ack     (int_ack),
        .cpu_int     (cpu_int),
        .cpu_int_ack (cpu_int_ack),
        .int_vector  (int_vector)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // One bus write, committed on the rising edge inside the step.
    task automatic bus_write(input logic [15:0] addr, input logic [7:0] data);
        a = addr; din = data; wr = 1'b1;
        step(1);
        wr = 1'b0;
    endtask

    task automatic set_addr(input logic [15:0] addr);
        a = addr;
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0; a = 16'h0000; din = 8'h00; rd = 1'b0; wr = 1'b0;
        int_req = 5'b00000; cpu_int_ack = 1'b0;
        step(3);
        total_cnt++; if (int_vector !== 8'h00) $display("FAIL rst_vector got %h exp 00", int_vector); else pass_cnt++;
        total_cnt++; if (int_ack !== 5'b00000) $display("FAIL rst_int_ack got %b exp 00000", int_ack); else pass_cnt++;
        total_cnt++; if (cpu_int !== 1'b0) $display("FAIL rst_cpu_int got %b exp 0", cpu_int); else pass_cnt++;
        rst = 1'b1;
        step(2);
        rd = 1'b1;
        set_addr(16'hFF0F);
        total_cnt++; if (dout !== 8'hE0) $display("FAIL rst_read_if got %h exp E0", dout); else pass_cnt++;
        set_addr(16'hFFFF);
        total_cnt++; if (dout !== 8'h00) $display("FAIL rst_read_ie got %h exp 00", dout); else pass_cnt++;
        set_addr(16'hFF10);
        total_cnt++; if (dout !== 8'hFF) $display("FAIL rst_read_unmapped got %h exp FF", dout); else pass_cnt++;
        rd = 1'b0;
    endtask

    task automatic test_single_dispatch;
        bus_write(16'hFFFF, 8'h04);
        int_req = 5'b00100;
        step(1);
        set_addr(16'hFF0F);
        total_cnt++; if (dout !== 8'hE4) $display("FAIL single_if_set got %h exp E4", dout); else pass_cnt++;
        total_cnt++; if (cpu_int !== 1'b1) $display("FAIL single_cpu_int got %b exp 1", cpu_int); else pass_cnt++;
        cpu_int_ack = 1'b1;
        step(1);
        total_cnt++; if (int_vector !== 8'h50) $display("FAIL single_vector got %h exp 50", int_vector); else pass_cnt++;
        total_cnt++; if (int_ack !== 5'b00100) $display("FAIL single_ack got %b exp 00100", int_ack); else pass_cnt++;
        step(1);
        total_cnt++; if (int_ack !== 5'b00000) $display("FAIL single_ack_once got %b exp 00000", int_ack); else pass_cnt++;
        total_cnt++; if (dout !== 8'hE0) $display("FAIL single_if_clear got %h exp E0", dout); else pass_cnt++;
        total_cnt++; if (int_vector !== 8'h50) $display("FAIL single_hold_vector got %h exp 50", int_vector); else pass_cnt++;
        cpu_int_ack = 1'b0;
        step(1);
        total_cnt++; if (int_vector !== 8'h00) $display("FAIL single_idle_vector got %h exp 00", int_vector); else pass_cnt++;
        int_req = 5'b00000;
        step(1);
    endtask

    task automatic test_priority;
        bus_write(16'hFFFF, 8'h1F);
        int_req = 5'b01010;
        step(1);
        set_addr(16'hFF0F);
        total_cnt++; if (dout !== 8'hEA) $display("FAIL prio_if_both got %h exp EA", dout); else pass_cnt++;
        cpu_int_ack = 1'b1;
        step(1);
        total_cnt++; if (int_vector !== 8'h48) $display("FAIL prio_first_vector got %h exp 48", int_vector); else pass_cnt++;
        total_cnt++; if (int_ack !== 5'b00010) $display("FAIL prio_first_ack got %b exp 00010", int_ack); else pass_cnt++;
        step(1);
        total_cnt++; if (dout !== 8'hE8) $display("FAIL prio_if_after got %h exp E8", dout); else pass_cnt++;
        cpu_int_ack = 1'b0;
        step(1);
        cpu_int_ack = 1'b1;
        step(1);
        total_cnt++; if (int_vector !== 8'h58) $display("FAIL prio_second_vector got %h exp 58", int_vector); else pass_cnt++;
        total_cnt++; if (int_ack !== 5'b01000) $display("FAIL prio_second_ack got %b exp 01000", int_ack); else pass_cnt++;
        step(1);
        cpu_int_ack = 1'b0;
        step(1);
        int_req = 5'b00000;
        total_cnt++; if (dout !== 8'hE0) $display("FAIL prio_if_empty got %h exp E0", dout); else pass_cnt++;
    endtask

    task automatic test_edge_beats_write;
        a = 16'hFF0F; din = 8'h00; wr = 1'b1; int_req = 5'b00001;
        step(1);
        wr = 1'b0;
        set_addr(16'hFF0F);
        total_cnt++; if (dout !== 8'hE1) $display("FAIL edge_vs_write got %h exp E1", dout); else pass_cnt++;
        // Level still high: no new edge, so the clear write sticks.
        bus_write(16'hFF0F, 8'h00);
        set_addr(16'hFF0F);
        total_cnt++; if (dout !== 8'hE0) $display("FAIL write_clear got %h exp E0", dout); else pass_cnt++;
        int_req = 5'b00000;
        step(1);
    endtask

    task automatic test_ack_without_int;
        bus_write(16'hFFFF, 8'h1F);
        cpu_int_ack = 1'b1;
        step(2);
        total_cnt++; if (int_vector !== 8'h00) $display("FAIL noint_vector got %h exp 00", int_vector); else pass_cnt++;
        total_cnt++; if (int_ack !== 5'b00000) $display("FAIL noint_ack got %b exp 00000", int_ack); else pass_cnt++;
        cpu_int_ack = 1'b0;
        step(1);
    endtask

    task automatic test_joypad;
        bus_write(16'hFFFF, 8'h10);
        int_req = 5'b10000;
        step(1);
        set_addr(16'hFFFF);
        total_cnt++; if (dout !== 8'h10) $display("FAIL joy_ie_read got %h exp 10", dout); else pass_cnt++;
        set_addr(16'hFF0F);
`ifdef INTC_JOYPAD_EN
        total_cnt++; if (dout !== 8'hF0) $display("FAIL joy_if got %h exp F0", dout); else pass_cnt++;
        total_cnt++; if (cpu_int !== 1'b1) $display("FAIL joy_cpu_int got %b exp 1", cpu_int); else pass_cnt++;
        cpu_int_ack = 1'b1;
        step(1);
        total_cnt++; if (int_vector !== 8'h60) $display("FAIL joy_vector got %h exp 60", int_vector); else pass_cnt++;
        total_cnt++; if (int_ack !== 5'b10000) $display("FAIL joy_ack got %b exp 10000", int_ack); else pass_cnt++;
        step(1);
        cpu_int_ack = 1'b0;
        step(1);
`else
        total_cnt++; if (dout !== 8'hE0) $display("FAIL joy_if got %h exp E0", dout); else pass_cnt++;
        total_cnt++; if (cpu_int !== 1'b0) $display("FAIL joy_cpu_int got %b exp 0", cpu_int); else pass_cnt++;
        cpu_int_ack = 1'b1;
        step(2);
        total_cnt++; if (int_ack !== 5'b00000) $display("FAIL joy_ack got %b exp 00000", int_ack); else pass_cnt++;
        cpu_int_ack = 1'b0;
        step(1);
`endif
        int_req = 5'b00000;
        step(1);
    endtask

    task automatic test_locked_dispatch;
        bus_write(16'hFFFF, 8'h04);
        int_req = 5'b00100;
        step(1);
        cpu_int_ack = 1'b1;
        step(1);
        // In GRANT: disable the source, and raise a higher-priority request.
        total_cnt++; if (int_vector !== 8'h50) $display("FAIL lock_grant_vector got %h exp 50", int_vector); else pass_cnt++;
        a = 16'hFFFF; din = 8'h00; wr = 1'b1; int_req = 5'b00101;
        step(1);
        wr = 1'b0;
        bus_write(16'hFFFF, 8'h01);
        total_cnt++; if (int_vector !== 8'h50) $display("FAIL lock_hold_vector got %h exp 50", int_vector); else pass_cnt++;
        total_cnt++; if (int_ack !== 5'b00000) $display("FAIL lock_hold_ack got %b exp 00000", int_ack); else pass_cnt++;
        set_addr(16'hFF0F);
        total_cnt++; if (dout !== 8'hE1) $display("FAIL lock_if_new got %h exp E1", dout); else pass_cnt++;
        cpu_int_ack = 1'b0;
        step(1);
        total_cnt++; if (int_vector !== 8'h00) $display("FAIL lock_idle_vector got %h exp 00", int_vector); else pass_cnt++;
        int_req = 5'b00000;
        bus_write(16'hFF0F, 8'h00);
    endtask

    task automatic test_reset_in_hold;
        bus_write(16'hFFFF, 8'h01);
        int_req = 5'b00001;
        step(1);
        cpu_int_ack = 1'b1;
        step(2);
        total_cnt++; if (int_vector !== 8'h40) $display("FAIL rhold_vector got %h exp 40", int_vector); else pass_cnt++;
        rst = 1'b0;
        #1;
        total_cnt++; if (int_vector !== 8'h00) $display("FAIL rhold_async_vector got %h exp 00", int_vector); else pass_cnt++;
        total_cnt++; if (cpu_int !== 1'b0) $display("FAIL rhold_cpu_int got %b exp 0", cpu_int); else pass_cnt++;
        step(2);
        rst = 1'b1;
        // Request and CPU ack held high across release: nothing may fire.
        for (int i = 0; i < 3; i++) begin
            step(1);
            total_cnt++; if (int_ack !== 5'b00000) $display("FAIL rhold_post_ack%0d got %b exp 00000", i, int_ack); else pass_cnt++;
        end
        set_addr(16'hFF0F);
        total_cnt++; if (dout !== 8'hE0) $display("FAIL rhold_level_no_if got %h exp E0", dout); else pass_cnt++;
        total_cnt++; if (int_vector !== 8'h00) $display("FAIL rhold_post_vector got %h exp 00", int_vector); else pass_cnt++;
        cpu_int_ack = 1'b0;
        int_req = 5'b00000;
        step(1);
    endtask

    initial begin
        test_reset();
        test_single_dispatch();
        test_priority();
        test_edge_beats_write();
        test_ack_without_int();
        test_joypad();
        test_locked_dispatch();
        test_reset_in_hold();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/interrupt_controller.md
INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port a  input  16  bus address.
REQ-004 SHALL have port din  input  8  bus write data.
REQ-005 SHALL have port dout  output  8  bus read data, combinational from a.
REQ-006 SHALL have port rd  input  1  bus read strobe.
REQ-007 SHALL have port wr  input  1  bus write strobe.
REQ-008 SHALL have port int_req  input  5  peripheral request levels; bit0 vblank, bit1 lcd stat, bit2 timer, bit3 serial, bit4 joypad.
REQ-009 SHALL have port int_ack  output  5  one-cycle acknowledge pulse per source.
REQ-010 SHALL have port cpu_int  output  1  high when (IE & IF & 5'h1F) != 0.
REQ-011 SHALL have port cpu_int_ack  input  1  CPU dispatch request; held high until dispatch completes.
REQ-012 SHALL have port int_vector  output  8  dispatch vector, valid while in GRANT or HOLD.

Function
REQ-013 SHALL implement IF at 0xFF0F (bits 4:0 stored, bits 7:5 read 1) and IE at 0xFFFF (8 bits stored).
REQ-014 SHALL drive dout = IF/IE for matching address, 8'hFF otherwise.
REQ-015 SHALL set IF[n] on rising edge of int_req[n] (registered previous level); IF bit visible one cycle after the edge cycle.
REQ-016 SHALL evaluate next IF as ((wr to 0xFF0F ? din[4:0] : IF) & ~dispatch_clear) | edges; edges win over writes and clears on the same bit.
REQ-017 SHALL implement FSM IDLE, GRANT, HOLD.
REQ-018 IDLE -> GRANT when cpu_int_ack=1 and cpu_int=1; cpu_int_ack with cpu_int=0 SHALL keep IDLE and int_vector=8'h00.
REQ-019 On IDLE->GRANT edge SHALL latch lowest-numbered pending enabled bit n (bit0 highest priority) and set int_vector = 8'h40 + 8*n.
REQ-020 In GRANT (exactly one cycle) SHALL clear IF[n] and pulse int_ack[n]; other int_ack bits 0.
REQ-021 GRANT -> HOLD unconditionally; HOLD -> IDLE when cpu_int_ack=0; int_vector held constant through HOLD.
REQ-022 SHALL not re-arbitrate until returning to IDLE; new requests during GRANT/HOLD only set IF.
REQ-023 IE/IF writes during GRANT/HOLD SHALL NOT change latched n or int_vector.
REQ-024 If IE[n] cleared after latch, dispatch SHALL still complete for n.

Reset
REQ-025 On rst low: IF=0, IE=0, previous-level regs=0, FSM=IDLE, int_ack=0, int_vector=8'h00, cpu_int=0; asynchronous assertion, synchronous-safe release.
REQ-026 Reset mid-dispatch SHALL abort to IDLE with no further int_ack pulse.
REQ-027 int_req held high across reset release SHALL NOT set IF (previous-level regs reset to 0 but sampled first cycle before edge check, i.e., first post-reset cycle only loads levels).

Configuration
REQ-028 Macro INTC_JOYPAD_EN: defined -> bit4 source fully functional; undefined -> IF[4] reads 0, never set, int_ack[4]=0, IE[4] still stored and readable.

Verification
REQ-029 Reset, then read 0xFF0F -> 8'hE0; read 0xFFFF -> 8'h00; read 0xFF10 -> 8'hFF.
REQ-030 IE=8'h04, pulse int_req[2] 0->1 -> IF reads 8'hE4 next cycle, cpu_int=1; assert cpu_int_ack -> int_vector=8'h50, int_ack=5'b00100 one cycle, IF=8'hE0; drop cpu_int_ack -> IDLE.
REQ-031 IE=8'h1F, edges on bits 1 and 3 same cycle, dispatch -> int_vector=8'h48, IF afterwards 8'hE8; second dispatch -> 8'h58.
REQ-032 Write 0xFF0F=8'h00 in same cycle as int_req[0] edge -> IF=8'hE1.
REQ-033 INTC_JOYPAD_EN undefined, IE=8'h10, int_req[4] edge -> IF=8'hE0, cpu_int=0; defined -> dispatch vector 8'h60.
REQ-034 Assert rst low during HOLD -> FSM IDLE, int_vector=8'h00, no int_ack pulse after release.
